// File: rtl/rvjtag_dtm.sv
// JTAG debug transport module: IEEE 1149.1 TAP, IDCODE/DTMCS/DMI/BYPASS registers
// and a DMI request/response handshake with sticky error tracking, all in the tck domain.
module rvjtag_dtm #(
  parameter int unsigned AWIDTH    = 7,
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned IR_LEN    = 5,
  parameter logic [2:0]  IDLE_HINT = 3'd1
) (
  input  logic              tck,
  input  logic              trst,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  output logic              tdo_en,
  output logic              dmi_req_valid,
  input  logic              dmi_req_ready,
  output logic [AWIDTH-1:0] dmi_req_addr,
  output logic [DWIDTH-1:0] dmi_req_data,
  output logic [1:0]        dmi_req_op,
  input  logic              dmi_rsp_valid,
  input  logic [DWIDTH-1:0] dmi_rsp_data,
  input  logic [1:0]        dmi_rsp_status,
  output logic              dmi_hard_reset,
  input  logic [30:0]       jtag_id,
  input  logic [3:0]        version
);

  localparam int unsigned DMI_LEN = AWIDTH + DWIDTH + 2;
  // DWIDTH >= 32 guarantees the DMI register is the longest data register.
  localparam int unsigned SR_W    = DMI_LEN;

  localparam logic [IR_LEN-1:0] IR_IDCODE = IR_LEN'(1);
  localparam logic [IR_LEN-1:0] IR_DTMCS  = IR_LEN'('h10);
  localparam logic [IR_LEN-1:0] IR_DMI    = IR_LEN'('h11);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_t;

  tap_state_t        state, state_n;
  logic [IR_LEN-1:0] ir;
  logic [SR_W-1:0]   sr, sr_shift;
  logic              sel_idcode, sel_dtmcs, sel_dmi;

  logic              busy, busy_n, busy_eff, rsp_take;
  logic [1:0]        sticky, sticky_n, sticky_eff;
  logic [DWIDTH-1:0] rsp_data, rsp_data_n, rsp_eff;
  logic [AWIDTH-1:0] last_addr, last_addr_n;
  logic              req_valid_n, hard_n;
  logic [AWIDTH-1:0] req_addr_n;
  logic [DWIDTH-1:0] req_data_n;
  logic [1:0]        req_op_n;
  logic              upd_dmi, upd_dtmcs;
  logic [31:0]       dtmcs_cap;
  logic [DMI_LEN-1:0] dmi_cap;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) state <= TLR;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      TLR:    state_n = tms ? TLR    : RTI;
      RTI:    state_n = tms ? SEL_DR : RTI;
      SEL_DR: state_n = tms ? SEL_IR : CAP_DR;
      CAP_DR: state_n = tms ? EX1_DR : SH_DR;
      SH_DR:  state_n = tms ? EX1_DR : SH_DR;
      EX1_DR: state_n = tms ? UPD_DR : PAU_DR;
      PAU_DR: state_n = tms ? EX2_DR : PAU_DR;
      EX2_DR: state_n = tms ? UPD_DR : SH_DR;
      UPD_DR: state_n = tms ? SEL_DR : RTI;
      SEL_IR: state_n = tms ? TLR    : CAP_IR;
      CAP_IR: state_n = tms ? EX1_IR : SH_IR;
      SH_IR:  state_n = tms ? EX1_IR : SH_IR;
      EX1_IR: state_n = tms ? UPD_IR : PAU_IR;
      PAU_IR: state_n = tms ? EX2_IR : PAU_IR;
      EX2_IR: state_n = tms ? UPD_IR : SH_IR;
      UPD_IR: state_n = tms ? SEL_DR : RTI;
      default: state_n = TLR;
    endcase
  end

  assign sel_idcode = (ir == IR_IDCODE);
  assign sel_dtmcs  = (ir == IR_DTMCS);
  assign sel_dmi    = (ir == IR_DMI);
  assign tdo_en     = (state == SH_DR) || (state == SH_IR);

  // A response arriving in the same cycle is folded in before capture/update decisions.
  assign rsp_take   = dmi_rsp_valid && busy;
  assign busy_eff   = busy && !dmi_rsp_valid;
  assign sticky_eff = (rsp_take && sticky == 2'd0) ? dmi_rsp_status : sticky;
  assign rsp_eff    = rsp_take ? dmi_rsp_data : rsp_data;

  assign dtmcs_cap = {14'b0, 2'b0, 1'b0, IDLE_HINT, sticky_eff, 6'(AWIDTH), version};
  assign dmi_cap   = {last_addr, rsp_eff, (busy_eff ? 2'd3 : sticky_eff)};

  always_comb begin
    sr_shift = sr >> 1;
    if (state == SH_IR)            sr_shift[IR_LEN-1]  = tdi;
    else if (sel_dmi)              sr_shift[DMI_LEN-1] = tdi;
    else if (sel_idcode || sel_dtmcs) sr_shift[31]     = tdi;
    else                           sr_shift[0]         = tdi;
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      sr <= '0;
    end else if (state == CAP_IR) begin
      sr <= SR_W'(1);
    end else if (state == SH_IR || state == SH_DR) begin
      sr <= sr_shift;
    end else if (state == CAP_DR) begin
      if (sel_dmi)         sr <= SR_W'(dmi_cap);
      else if (sel_idcode) sr <= SR_W'({jtag_id, 1'b1});
      else if (sel_dtmcs)  sr <= SR_W'(dtmcs_cap);
      else                 sr <= '0;
    end
  end

  // IR and tdo move on the falling edge so the host samples stable values.
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      ir  <= IR_LEN'(1);
      tdo <= 1'b0;
    end else begin
      tdo <= sr[0];
      if (state == TLR)
        ir <= IR_LEN'(1);
      else if (state == UPD_IR)
        ir <= (sr[IR_LEN-1:0] == '0) ? '1 : sr[IR_LEN-1:0];
    end
  end

  assign upd_dmi   = (state == UPD_DR) && sel_dmi;
  assign upd_dtmcs = (state == UPD_DR) && sel_dtmcs;

  always_comb begin
    busy_n      = busy_eff;
    sticky_n    = sticky_eff;
    rsp_data_n  = rsp_eff;
    last_addr_n = last_addr;
    req_valid_n = dmi_req_valid && !dmi_req_ready;
    req_addr_n  = dmi_req_addr;
    req_data_n  = dmi_req_data;
    req_op_n    = dmi_req_op;
    hard_n      = 1'b0;
    if (state == CAP_DR && sel_dmi && busy_eff)
      sticky_n = 2'd3;
    if (upd_dmi && (sr[1:0] == 2'd1 || sr[1:0] == 2'd2)) begin
      if (busy_eff) begin
        sticky_n = 2'd3;
      end else if (sticky_eff == 2'd0) begin
        req_valid_n = 1'b1;
        req_addr_n  = sr[DMI_LEN-1:DWIDTH+2];
        req_data_n  = sr[DWIDTH+1:2];
        req_op_n    = sr[1:0];
        busy_n      = 1'b1;
        last_addr_n = sr[DMI_LEN-1:DWIDTH+2];
      end
    end
    if (upd_dtmcs && sr[16])
      sticky_n = 2'd0;
    // Hard reset overrides everything, including a response landing this cycle.
    if (upd_dtmcs && sr[17]) begin
      hard_n      = 1'b1;
      busy_n      = 1'b0;
      sticky_n    = 2'd0;
      req_valid_n = 1'b0;
      rsp_data_n  = rsp_data;
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      busy           <= 1'b0;
      sticky         <= 2'd0;
      rsp_data       <= '0;
      last_addr      <= '0;
      dmi_req_valid  <= 1'b0;
      dmi_req_addr   <= '0;
      dmi_req_data   <= '0;
      dmi_req_op     <= 2'd0;
      dmi_hard_reset <= 1'b0;
    end else begin
      busy           <= busy_n;
      sticky         <= sticky_n;
      rsp_data       <= rsp_data_n;
      last_addr      <= last_addr_n;
      dmi_req_valid  <= req_valid_n;
      dmi_req_addr   <= req_addr_n;
      dmi_req_data   <= req_data_n;
      dmi_req_op     <= req_op_n;
      dmi_hard_reset <= hard_n;
    end
  end

endmodule

// File: doc/rvjtag_dtm.md
# rvjtag_dtm

Parametrised JTAG debug transport module that supersedes the fixed-width TAP. It provides the IEEE 1149.1 TAP controller, a configurable-length IR, IDCODE/DTMCS/DMI/BYPASS data registers, and a real DMI request/response handshake toward the debug module. It adds in-flight tracking with sticky busy/failed status and dmireset/dmihardreset recovery. It runs entirely in the tck domain; CDC to the core clock is done by the DMI wrapper.

## Interface
- AWIDTH, 7, DMI address width (1..63)
- DWIDTH, 32, DMI data width (≥32)
- IR_LEN, 5, instruction register length (≥5)
- IDLE_HINT, 3'd1, value reported in dtmcs.idle
- tck  in  1  JTAG clock
- trst  in  1  reset, asynchronous, active-low
- tms, tdi  in  1  JTAG inputs
- tdo  out  1  serial out, reg, changes on negedge tck
- tdo_en  out  1  shift_dr | shift_ir
- dmi_req_valid  out  1  request pending
- dmi_req_ready  in  1  DM accepts request
- dmi_req_addr  out  AWIDTH  request address
- dmi_req_data  out  DWIDTH  write data
- dmi_req_op  out  2  1=read, 2=write
- dmi_rsp_valid  in  1  one-tck response strobe
- dmi_rsp_data  in  DWIDTH  read data
- dmi_rsp_status  in  2  0 ok, 2 failed, 3 busy
- dmi_hard_reset  out  1  one-tck pulse
- jtag_id  in  31  IDCODE[31:1]; bit 0 forced 1
- version  in  4  dtmcs.version

## Operation
- TAP FSM: standard 16 states; TMS-driven transitions on posedge tck; trst or 5 × TMS=1 reaches Test-Logic-Reset (TLR).
- IR: updated on negedge tck in Update-IR from shift reg [IR_LEN-1:0]; an all-zero value is stored as all-ones. TLR and trst load IDCODE=1. Capture-IR loads ...01.
- Decode: 1 = IDCODE (32b), 0x10 = DTMCS (32b), 0x11 = DMI (AWIDTH+DWIDTH+2). Every other value selects BYPASS (1b, captures 0).
- Shift: LSB first; tdi enters the MSB of the selected DR length.
- DTMCS capture: {14'b0, 2'b0, 1'b0, IDLE_HINT, sticky, AWIDTH[5:0], version}.
- DTMCS update: bit16 (dmireset) clears sticky. Bit17 (dmihardreset) pulses dmi_hard_reset and clears busy, sticky and dmi_req_valid. The stored response is unchanged.
- DMI state: busy (request issued, response not yet received) and sticky[1:0] (0 = none, 2 = failed, 3 = busy error).
- DMI capture:
  - If busy: sticky ← 3 and capture {last_addr, rsp_data_reg, 2'd3}.
  - Otherwise: capture {last_addr, rsp_data_reg, sticky}.
- DMI update with op ∈ {1,2}, sticky = 0 and busy = 0:
  - Load req addr/data/op, assert dmi_req_valid, set busy, last_addr ← addr.
- DMI update while busy: sticky ← 3 and the request is dropped.
- DMI update while sticky ≠ 0: the request is dropped.
- op 0 is a nop. op 3 is ignored.
- Handshake: dmi_req_valid holds with stable addr/data/op until sampled with dmi_req_ready = 1; it deasserts the next cycle.
- Response: on dmi_rsp_valid, busy ← 0 and rsp_data_reg ← dmi_rsp_data. If status ≠ 0 and sticky = 0, sticky ← status. rsp_valid is ignored when busy = 0.
- TLR does not clear busy, sticky or an outstanding request. Only trst and dmihardreset do.

## Timing
- Reset values on trst:
  - FSM = TLR, IR = 1, shift reg = 0, tdo = 0.
  - dmi_req_valid = 0, addr/data/op = 0, dmi_hard_reset = 0.
  - busy = 0, sticky = 0, rsp_data_reg = 0, last_addr = 0.
- Capture and shift registers update on posedge tck. IR and tdo update on negedge tck. tdo = shift_reg[0], retimed.
- dmi_req_valid rises on the posedge tck at which state == Update-DR, so it is visible 1 tck after entry.
- dmi_hard_reset is high for exactly the 1 tck following Update-DR of DTMCS.
- Same-cycle dmi_rsp_valid and a Capture-DR of DMI: the response is applied first, so the capture sees busy = 0 and the new data.
- Same-cycle rsp_valid and hard reset: hard reset wins.
- Same-cycle rsp_valid and dmireset: dmireset wins (sticky = 0).
- A req_ready/rsp_valid pair may arrive in the same cycle for zero-latency DMs.

## Test plan
- trst low, release, 5 × TMS=1, Shift-DR 32 bits → tdo stream = {jtag_id, 1}; IR capture shifts out 5'b00001.
- IR = 5'b00000 then 5'b01010 → BYPASS: tdi pattern 1011 appears on tdo delayed 1 tck. Verify IR read-back = 5'b11111 for the all-zero write.
- DMI write addr 0x10, data 0xDEADBEEF, op 2, DM ready immediately, rsp status 0 → one req_valid cycle with matching fields. Next DMI capture returns op = 0.
- DMI read issued, DM holds rsp 20 tck, second DMI capture meanwhile → captured op = 3, sticky = 3. A following DMI write is dropped (no req_valid). dtmcs.dmistat = 3. Writing dmireset → dmistat = 0 and the next request is issued.
- Response status 2 → dmistat = 2. A subsequent status-0 response leaves sticky at 2.
- Outstanding request with dmi_req_ready = 0, then dmihardreset → dmi_hard_reset 1-tck pulse; req_valid, busy and sticky all 0 the next cycle. Async trst mid-Shift-DR returns all outputs to reset values with no tck edge.
